// File: rtl/aes_lite_pkg.sv
`default_nettype none
// ============================================================================
// aes_lite_pkg : shared types and constants for the AES-lite scheduler slice.
// Revision: 1.0
// ============================================================================
package aes_lite_pkg;

    localparam int AES_BYTE_W  = 8;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_TIMEOUT = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_t;

    // Index width for n clients; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_lite_rr_arbiter.sv
`default_nettype none
// ============================================================================
// aes_lite_rr_arbiter : combinational round-robin pick, first valid at/after rr_ptr.
// Revision: 1.0
// ============================================================================
module aes_lite_rr_arbiter
    import aes_lite_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_any
);

    logic [ID_W:0]   w_pos;
    logic [ID_W-1:0] w_cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        w_pos     = '0;
        w_cand    = '0;
        // Walk from the farthest candidate back so the one nearest rr_ptr wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_pos = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (w_pos >= (ID_W + 1)'(NUM_REQ)) begin
                w_pos = w_pos - (ID_W + 1)'(NUM_REQ);
            end
            w_cand = w_pos[ID_W-1:0];
            if (req_valid[w_cand]) begin
                grant_any = 1'b1;
                grant_idx = w_cand;
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_lite_sched.sv
`default_nettype none
// ============================================================================
// aes_lite_sched : round-robin scheduler sharing one AES-lite byte core.
// Optional BUSY watchdog: define AES_LITE_SCHED_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module aes_lite_sched
    import aes_lite_pkg::*;
#(
    parameter int  NUM_REQ = DEF_NUM_REQ,
    parameter int  TIMEOUT = DEF_TIMEOUT,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [AES_BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [AES_BYTE_W*NUM_REQ-1:0] req_key,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          core_start,
    output logic [AES_BYTE_W-1:0]         core_data,
    output logic [AES_BYTE_W-1:0]         core_key,
    input  logic                          core_done,
    input  logic [AES_BYTE_W-1:0]         core_result,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [AES_BYTE_W-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic                          busy
);

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [ID_W-1:0]       r_hold_id;
    logic [AES_BYTE_W-1:0] r_hold_data;
    logic [AES_BYTE_W-1:0] r_hold_key;
    logic [AES_BYTE_W-1:0] r_rsp_data;
    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_W-1:0]       w_grant_idx;
    logic                  w_grant_any;
    logic                  w_timeout;

    logic [AES_BYTE_W-1:0] w_data_arr [NUM_REQ];
    logic [AES_BYTE_W-1:0] w_key_arr  [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_data_arr[gi] = req_data[gi*AES_BYTE_W +: AES_BYTE_W];
        assign w_key_arr[gi]  = req_key[gi*AES_BYTE_W +: AES_BYTE_W];
    end

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("aes_lite_sched: TIMEOUT must fit the 8-bit watchdog (1..255)");
    end

    aes_lite_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .grant_any (w_grant_any)
    );

`ifdef AES_LITE_SCHED_TIMEOUT_EN
    logic [7:0] r_to_cnt;
    logic       r_rsp_err;

    // Held at zero outside BUSY, so every BUSY entry starts a fresh count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (r_state != ST_BUSY) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 8'd1;
        end
    end

    assign w_timeout = (r_state == ST_BUSY) && (r_to_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_err <= 1'b0;
        end else if (r_state == ST_BUSY) begin
            if (core_done) begin
                r_rsp_err <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_err <= 1'b1;
            end
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        core_start  = 1'b0;
        rsp_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy      = 1'b0;
                req_ready = w_grant;
                if (w_grant_any) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                core_start  = 1'b1;
                w_state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (core_done || w_timeout) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_hold_id   <= '0;
            r_hold_data <= '0;
            r_hold_key  <= '0;
            r_rsp_data  <= '0;
        end else begin
            if (r_state == ST_IDLE && w_grant_any) begin
                r_hold_id   <= w_grant_idx;
                r_hold_data <= w_data_arr[w_grant_idx];
                r_hold_key  <= w_key_arr[w_grant_idx];
            end
            // A done in the limit cycle takes priority over the watchdog.
            if (r_state == ST_BUSY) begin
                if (core_done) begin
                    r_rsp_data <= core_result;
                end else if (w_timeout) begin
                    r_rsp_data <= '0;
                end
            end
            if (r_state == ST_RESP && rsp_ready) begin
                r_rr_ptr <= (r_hold_id == ID_W'(NUM_REQ - 1)) ? '0 : r_hold_id + ID_W'(1);
            end
        end
    end

    assign core_data = r_hold_data;
    assign core_key  = r_hold_key;
    assign rsp_id    = r_hold_id;
    assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: doc/aes_lite_sched.md
Name: aes_lite_sched

Overview:
Round-robin scheduler that shares one AES-lite byte-encryption core between NUM_REQ requesters.
- Accepts a data/key byte pair per requester over a valid/ready handshake.
- Sequences the core with a one-cycle start pulse and waits for its one-cycle done pulse.
- Returns the result with the requester ID over a backpressured response channel.
- Sits between tile-level I/O muxing and the AES-lite round core.

Parameters:
NUM_REQ, 4, number of requesters (2..8); ID width = clog2(NUM_REQ).
TIMEOUT, 32, BUSY-cycle limit before abort (used only with the optional feature).

Ports:
clk  in  1  clock.
rst_n  in  1  synchronous active-low reset.
req_valid  in  NUM_REQ  per-requester request valid.
req_data  in  8*NUM_REQ  plaintext byte, requester i at [8i+7:8i].
req_key  in  8*NUM_REQ  key byte, same packing.
req_ready  out  NUM_REQ  one-hot accept pulse.
core_start  out  1  one-cycle start pulse to the core.
core_data  out  8  plaintext to the core.
core_key  out  8  key to the core.
core_done  in  1  core ready/done pulse.
core_result  in  8  core output byte, valid when core_done=1.
rsp_valid  out  1  response valid.
rsp_ready  in  1  response accept.
rsp_id  out  clog2(NUM_REQ)  requester index of the response.
rsp_data  out  8  encrypted byte.
rsp_err  out  1  timeout abort flag.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: on a clk edge with rst_n=0, all outputs and registers go to 0, FSM to IDLE, rr_ptr to 0.
  - Reset mid-operation abandons the transaction; no response is produced.
  - A later core_done is ignored because the FSM is not in BUSY.
- FSM states: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - If any req_valid, grant the first set bit at or after rr_ptr, searching upward with wrap to 0.
  - req_ready[g]=1 combinationally in that cycle only.
  - Capture data, key and g into hold registers; go to ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE:
  - core_start=1 for exactly one cycle; go to BUSY.
  - core_data/core_key drive the hold registers from ISSUE through RESP and hold their value otherwise.
- BUSY:
  - On core_done=1, register core_result into rsp_data, clear rsp_err, go to RESP.
  - core_done in any other state is ignored.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err stay stable until the handshake.
  - On rsp_valid&&rsp_ready, in that same cycle set rr_ptr=(id+1) mod NUM_REQ and go to IDLE.
  - rsp_valid deasserts in the next cycle.
- Throughput:
  - Requests are not accepted outside IDLE, so at most one transaction is in flight.
  - Minimum spacing between accepts = 3 + core latency + response wait.
- Fairness: a requester holding req_valid is served within NUM_REQ transactions.
- Latency:
  - req_ready to core_start: 1 cycle.
  - core_done to rsp_valid: 1 cycle.
  - rsp_ready to next req_ready: 1 cycle.
- Wrap-around: the rr_ptr increment wraps NUM_REQ-1 to 0. Non-power-of-two NUM_REQ uses an explicit compare, not truncation.

Optional Feature:
AES_LITE_SCHED_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT with no core_done, go to RESP with rsp_err=1 and rsp_data=0x00.
  - core_done arriving in the same cycle as the limit wins: normal response, rsp_err=0.
- Undefined: no counter is built; rsp_err is tied to 0; BUSY waits indefinitely.

Decomposition:
- Package aes_lite_pkg holds:
  - FSM state enum (IDLE/ISSUE/BUSY/RESP);
  - AES_BYTE_W=8;
  - default NUM_REQ and TIMEOUT constants;
  - the ID-width function.
- One sub-module: aes_lite_rr_arbiter. It is combinational: req_valid plus rr_ptr in, one-hot grant plus encoded index out. It is reused by future multi-client blocks.

Test Plan:
- Single request: req_valid=0001, data=0x3C, key=0xA5; core stub returns data^key after 12 cycles.
  -> req_ready=0001 for one cycle, one core_start pulse, then rsp_valid with id=0, data=0x99.
- All four requesters valid continuously, starting from rr_ptr=0.
  -> Grant order 0,1,2,3,0; every response id matches its grant.
- rsp_ready held 0 for 5 cycles in RESP.
  -> rsp_valid/id/data stay stable; no req_ready pulses; release completes one response.
- Reset pulse during BUSY, then core_done 2 cycles after release.
  -> All outputs 0 after reset; no rsp_valid; next request starts from grant 0.
- Spurious core_done in IDLE and in RESP.
  -> No state change; rsp_data unchanged.
- With AES_LITE_SCHED_TIMEOUT_EN, stub never asserts done.
  -> rsp_valid rises 33 cycles after core_start (TIMEOUT=32) with rsp_err=1, rsp_data=0x00.
